// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage data memory access unit.
package mem_access_pkg;

    localparam int ADDR_W_DEFAULT = 7;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } state_t;

endpackage

// File: rtl/byte_lane_align.sv
// Little-endian lane steering: load extract/extend and sub-word store merge.
module byte_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_signed,
    output logic [31:0] load_data,
    input  logic [31:0] old_word,
    input  logic [15:0] new_data,
    output logic [31:0] merge_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        load_data = rd_word;
        case (lane)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            SIZE_BYTE: load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data = {{16{is_signed & half_sel[15]}}, half_sel};
            default:   load_data = rd_word;
        endcase
    end

    always_comb begin
        merge_word = old_word;
        case (size)
            SIZE_BYTE: begin
                case (lane)
                    2'd0:    merge_word[7:0]   = new_data[7:0];
                    2'd1:    merge_word[15:8]  = new_data[7:0];
                    2'd2:    merge_word[23:16] = new_data[7:0];
                    default: merge_word[31:24] = new_data[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (lane[1])
                    merge_word[31:16] = new_data;
                else
                    merge_word[15:0] = new_data;
            end
            default: merge_word = old_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: handshake, fault check, load extension and sub-word RMW.
// Define MEM_ACCESS_RANGE_CHECK_EN to fault on addresses beyond the memory.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_fault,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    state_t              state, state_next;
    logic                write_q, signed_q, resp_fault_q;
    logic [1:0]          size_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q, merge_q, resp_rdata_q, mem_wdata_q;
    logic                req_fault;
    logic [31:0]         load_data, merge_word;
    logic                word_store;
    logic                unused_upper;

    assign unused_upper = ^req_addr[31:ADDR_W+2];

    always_comb begin
        req_fault = 1'b0;
        case (req_size)
            SIZE_BYTE: req_fault = 1'b0;
            SIZE_HALF: req_fault = req_addr[0];
            SIZE_WORD: req_fault = (req_addr[1:0] != 2'b00);
            default:   req_fault = 1'b1;
        endcase
`ifdef MEM_ACCESS_RANGE_CHECK_EN
        if (req_addr[31:ADDR_W+2] != '0)
            req_fault = 1'b1;
`endif
    end

    byte_lane_align u_align (
        .rd_word    (mem_read_data),
        .size       (size_q),
        .lane       (addr_q[1:0]),
        .is_signed  (signed_q),
        .load_data  (load_data),
        .old_word   (merge_q),
        .new_data   (wdata_q[15:0]),
        .merge_word (merge_word)
    );

    assign word_store = write_q && (size_q == SIZE_WORD);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = req_fault ? RESP : ACCESS;
            ACCESS:  state_next = (write_q && !word_store) ? WRITE : RESP;
            WRITE:   state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= SIZE_BYTE;
            addr_q       <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q      <= req_write;
                        signed_q     <= req_signed;
                        size_q       <= req_size;
                        addr_q       <= req_addr[ADDR_W+1:0];
                        wdata_q      <= req_wdata;
                        resp_fault_q <= req_fault;
                        resp_rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    if (!write_q)
                        resp_rdata_q <= load_data;
                    else if (word_store)
                        mem_wdata_q <= wdata_q;
                    else
                        merge_q <= mem_read_data;
                end
                WRITE:   mem_wdata_q <= merge_word;
                default: ;
            endcase
        end
    end

    // The write-data port is live in the write cycle and otherwise holds the last word written.
    always_comb begin
        mem_write_data = mem_wdata_q;
        if (state == ACCESS && word_store)
            mem_write_data = wdata_q;
        else if (state == WRITE)
            mem_write_data = merge_word;
    end

    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign resp_fault  = resp_fault_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_address = addr_q[ADDR_W+1:2];
    assign mem_read    = reset_n && (state == ACCESS) && !word_store;
    assign mem_write   = reset_n && ((state == ACCESS && word_store) || state == WRITE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit with a 128-word memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [6:0]  mem_address;
    logic        mem_read, mem_write;
    logic [31:0] mem_write_data, mem_read_data;

    logic [31:0] tbMem [0:127];
    logic        bothSeen = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expFault;
        logic [31:0] expRdata;
        int          expLat;
        logic [6:0]  expAddr;
        logic [31:0] expWdata;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_fault     (resp_fault),
        .resp_rdata     (resp_rdata),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = tbMem[mem_address];

    always @(posedge clk) begin
        if (mem_write)
            tbMem[mem_address] <= mem_write_data;
    end

    always @(negedge clk) begin
        if (mem_read && mem_write)
            bothSeen <= 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic wr, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic expFault, input logic [31:0] expRdata, input int expLat,
                                input logic [6:0] expAddr, input logic [31:0] expWdata);
        vec_t v;
        v.name = name; v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.expFault = expFault; v.expRdata = expRdata; v.expLat = expLat;
        v.expAddr = expAddr; v.expWdata = expWdata;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        int          lat;
        logic        done, sawRd, sawWr, firstRd, firstWr;
        logic [6:0]  addrSeen;
        logic [31:0] wdSeen;
        lat = 0; done = 0; sawRd = 0; sawWr = 0; firstRd = 0; firstWr = 0;
        addrSeen = '0; wdSeen = '0;
        @(negedge clk);
        checkOutput({v.name, ".ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (!done && lat < 10) begin
            lat++;
            @(negedge clk);
            if (resp_valid) begin
                done = 1'b1;
            end else begin
                if (lat == 1) begin
                    firstRd  = mem_read;
                    firstWr  = mem_write;
                    addrSeen = mem_address;
                end
                sawRd = sawRd | mem_read;
                if (mem_write) begin
                    sawWr  = 1'b1;
                    wdSeen = mem_write_data;
                end
                @(posedge clk);
            end
        end
        checkOutput({v.name, ".done"}, 32'(done), 32'd1);
        checkOutput({v.name, ".latency"}, 32'(lat), 32'(v.expLat));
        checkOutput({v.name, ".fault"}, 32'(resp_fault), 32'(v.expFault));
        checkOutput({v.name, ".rdata"}, resp_rdata, v.expRdata);
        if (v.expFault) begin
            checkOutput({v.name, ".noRead"}, 32'(sawRd), 32'd0);
            checkOutput({v.name, ".noWrite"}, 32'(sawWr), 32'd0);
        end else begin
            checkOutput({v.name, ".addr"}, 32'(addrSeen), 32'(v.expAddr));
            checkOutput({v.name, ".firstRead"}, 32'(firstRd), 32'(!(v.wr && v.size == 2'b10)));
            if (v.wr) begin
                checkOutput({v.name, ".wrote"}, 32'(sawWr), 32'd1);
                checkOutput({v.name, ".wdata"}, wdSeen, v.expWdata);
                if (v.size != 2'b10)
                    checkOutput({v.name, ".firstNoWrite"}, 32'(firstWr), 32'd0);
            end else begin
                checkOutput({v.name, ".loadNoWrite"}, 32'(sawWr), 32'd0);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;

        vecs.push_back(mk("st_w0",    1, 2'b10, 0, 32'h000, 32'h5A5A5A5A, 0, 32'h0,        2, 7'd0,  32'h5A5A5A5A));
        vecs.push_back(mk("st_w10",   1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 0, 32'h0,        2, 7'd4,  32'hDEADBEEF));
        vecs.push_back(mk("ld_w10",   0, 2'b10, 0, 32'h010, 32'h0,        0, 32'hDEADBEEF, 2, 7'd4,  32'h0));
        vecs.push_back(mk("st_w20",   1, 2'b10, 0, 32'h020, 32'h11223344, 0, 32'h0,        2, 7'd8,  32'h11223344));
        vecs.push_back(mk("st_b22",   1, 2'b00, 0, 32'h022, 32'h123456AA, 0, 32'h0,        3, 7'd8,  32'h11AA3344));
        vecs.push_back(mk("ld_w20",   0, 2'b10, 0, 32'h020, 32'h0,        0, 32'h11AA3344, 2, 7'd8,  32'h0));
        vecs.push_back(mk("st_w40",   1, 2'b10, 0, 32'h040, 32'h80FF7F01, 0, 32'h0,        2, 7'd16, 32'h80FF7F01));
        vecs.push_back(mk("ld_sb42",  0, 2'b00, 1, 32'h042, 32'h0,        0, 32'hFFFFFFFF, 2, 7'd16, 32'h0));
        vecs.push_back(mk("ld_ub42",  0, 2'b00, 0, 32'h042, 32'h0,        0, 32'h000000FF, 2, 7'd16, 32'h0));
        vecs.push_back(mk("ld_sh42",  0, 2'b01, 1, 32'h042, 32'h0,        0, 32'hFFFF80FF, 2, 7'd16, 32'h0));
        vecs.push_back(mk("ld_sb41",  0, 2'b00, 1, 32'h041, 32'h0,        0, 32'h0000007F, 2, 7'd16, 32'h0));
        vecs.push_back(mk("ld_uh40",  0, 2'b01, 0, 32'h040, 32'h0,        0, 32'h00007F01, 2, 7'd16, 32'h0));
        vecs.push_back(mk("st_b43",   1, 2'b00, 0, 32'h043, 32'h00000012, 0, 32'h0,        3, 7'd16, 32'h12FF7F01));
        vecs.push_back(mk("st_h12",   1, 2'b01, 0, 32'h012, 32'h1234CAFE, 0, 32'h0,        3, 7'd4,  32'hCAFEBEEF));
        vecs.push_back(mk("ld_sb13",  0, 2'b00, 1, 32'h013, 32'h0,        0, 32'hFFFFFFCA, 2, 7'd4,  32'h0));
        vecs.push_back(mk("flt_h31",  0, 2'b01, 0, 32'h031, 32'h0,        1, 32'h0,        1, 7'd0,  32'h0));
        vecs.push_back(mk("flt_w32",  1, 2'b10, 0, 32'h032, 32'hFFFFFFFF, 1, 32'h0,        1, 7'd0,  32'h0));
        vecs.push_back(mk("flt_rsvd", 0, 2'b11, 0, 32'h000, 32'h0,        1, 32'h0,        1, 7'd0,  32'h0));
`ifdef MEM_ACCESS_RANGE_CHECK_EN
        vecs.push_back(mk("ld_w200",  0, 2'b10, 0, 32'h200, 32'h0,        1, 32'h0,        1, 7'd0,  32'h0));
`else
        vecs.push_back(mk("ld_w200",  0, 2'b10, 0, 32'h200, 32'h0,        0, 32'h5A5A5A5A, 2, 7'd0,  32'h0));
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst.ready",  32'(req_ready),  32'd1);
        checkOutput("rst.valid",  32'(resp_valid), 32'd0);
        checkOutput("rst.fault",  32'(resp_fault), 32'd0);
        checkOutput("rst.rdata",  resp_rdata,      32'd0);
        checkOutput("rst.mrd",    32'(mem_read),   32'd0);
        checkOutput("rst.mwr",    32'(mem_write),  32'd0);
        checkOutput("rst.maddr",  32'(mem_address), 32'd0);
        checkOutput("rst.mwdata", mem_write_data,  32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i]);

        // Reset asserted in the WRITE cycle of a byte store must drop the write.
        @(negedge clk);
        checkOutput("rmw.ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h020; req_wdata = 32'h00000055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rmw.accessRead", 32'(mem_read), 32'd1);
        @(negedge clk);
        checkOutput("rmw.writeStrobe", 32'(mem_write), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("rmw.gatedWrite", 32'(mem_write), 32'd0);
        @(negedge clk);
        checkOutput("rmw.postReady", 32'(req_ready),  32'd1);
        checkOutput("rmw.postValid", 32'(resp_valid), 32'd0);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rmw.noResp", 32'(resp_valid), 32'd0);
        end
        checkOutput("rmw.memKept", tbMem[8], 32'h11AA3344);

        checkOutput("never.bothStrobes", 32'(bothSeen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator for the word-addressed data memory (7-bit word address, 32-bit data, single-cycle synchronous write, combinational read).
- Accepts byte, halfword and word loads/stores from the pipeline over a valid/ready handshake.
- Performs lane selection and sign/zero extension for loads.
- Performs read-modify-write for sub-word stores, since the memory only writes whole words.
- Returns a registered response pulse, with a fault flag for illegal accesses.

Parameters:
- ADDR_W, 7, word-address width of the memory port; byte address uses bits [ADDR_W+1:0].

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  sign-extend loads (ignored for stores)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; byte/half taken from the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_fault  out  1  access rejected; qualified by resp_valid
- resp_rdata  out  32  extended load data; 0 for stores and faults
- mem_address  out  ADDR_W  word address = addr_q[ADDR_W+1:2]
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_write_data  out  32  word to write
- mem_read_data  in  32  combinational read data from memory

Behaviour:
- Reset:
  - reset_n low at a rising edge forces state IDLE and clears all request/response registers.
  - Reset output values: req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
  - mem_read and mem_write are gated by reset_n, so they are 0 in any cycle where reset_n is low.
  - An in-flight request is dropped with no response.
- Handshake:
  - req_ready = (state==IDLE).
  - A request is accepted on a rising edge with req_valid & req_ready; all request fields are latched into *_q registers.
  - Inputs are don't-care when not accepted.
- Fault check at acceptance:
  - Conditions: size 11; half with addr[0]=1; word with addr[1:0]!=0.
  - A faulting request goes IDLE -> RESP with fault=1 and makes no memory access.
- FSM states: IDLE, ACCESS, WRITE, RESP.
  - ACCESS, load: mem_read=1; capture the extended lane of mem_read_data into resp_rdata -> RESP.
  - ACCESS, word store: mem_write=1, mem_write_data=wdata_q -> RESP.
  - ACCESS, byte/half store: mem_read=1, mem_write=0 (required because memory read data bypasses write data when written); capture mem_read_data into merge_q -> WRITE.
  - WRITE: mem_write=1, mem_write_data = merge_q with the target lane replaced by wdata_q low byte/half -> RESP.
  - RESP: resp_valid=1 for exactly one cycle; outputs hold the captured values -> IDLE.
- Memory-port values outside active states:
  - mem_read and mem_write are never 1 simultaneously.
  - Both are 0 in IDLE and RESP.
  - mem_address and mem_write_data hold their last values outside ACCESS/WRITE.
- Lanes (little-endian): byte lane = addr[1:0], byte 0 = bits [7:0]; half lane = addr[1], half 0 = bits [15:0].
- Extension:
  - req_signed=1: replicate the lane MSB.
  - Otherwise: zero-fill.
  - Word loads pass through unchanged.
- Latency, in rising edges from acceptance to resp_valid high:
  - fault 1
  - load / word store 2
  - sub-word store 3
- Throughput: next acceptance is possible the edge after RESP.
- Upper address bits [31:ADDR_W+2] are ignored (aliasing) unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_ACCESS_RANGE_CHECK_EN.
- Defined: req_addr[31:ADDR_W+2] != 0 is a fault, handled exactly as misalignment (no memory access, 1-edge fault response).
- Undefined: no range check; upper bits are silently dropped.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SIZE_BYTE/HALF/WORD/RSVD
  - FSM state enum
  - default ADDR_W
- Sub-module byte_lane_align (combinational) holds:
  - load extract/extend: word, size, lane, signed -> 32-bit
  - store merge: old word, new data, size, lane -> word
- The FSM and registers stay in mem_access_unit.

Test Plan:
- Word store 0xDEADBEEF at addr 0x10, then word load 0x10:
  - store: mem_write=1 with mem_address=4 in the ACCESS cycle
  - load: resp_rdata=0xDEADBEEF, resp_valid 2 edges after accept
- With word 0x11223344 at addr 0x20, store byte 0xAA at 0x22:
  - ACCESS cycle: mem_read=1, mem_write=0
  - WRITE cycle: mem_write_data=0x11AA3344
  - resp_valid 3 edges after accept
- With word 0x80FF7F01 at addr 0x40:
  - signed byte load at 0x42 -> 0xFFFFFFFF
  - unsigned byte load at 0x42 -> 0x000000FF
  - signed half load at 0x42 -> 0xFFFF80FF
  - signed byte load at 0x41 -> 0x0000007F
- Half load at 0x31, word store at 0x32, size 11:
  - each gives resp_valid=1 with resp_fault=1, 1 edge after accept
  - mem_read=mem_write=0 throughout
- Reset mid-RMW:
  - reset_n low during the WRITE state -> mem_write=0 that cycle
  - next edge: IDLE, req_ready=1, no resp_valid
  - memory word unchanged
- With MEM_ACCESS_RANGE_CHECK_EN, load at 0x00000200 -> resp_fault=1.
- Without MEM_ACCESS_RANGE_CHECK_EN, load at 0x00000200 -> reads word 0 (mem_address=0).
